// File: rtl/gpio_test_pkg.sv
// Shared types and helpers for the GPIO walking-one loopback master:
// register type codes, state encoding and address composition.
package gpio_test_pkg;

    typedef enum logic [1:0] {
        TYPE_IN  = 2'b00,
        TYPE_OUT = 2'b01,
        TYPE_OE  = 2'b10
    } xfer_type_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OE_WR,
        ST_OUT_WR,
        ST_SETTLE,
        ST_IN_RD,
        ST_CHECK,
        ST_REL_OE,
        ST_REL_OUT,
        ST_DONE
    } state_e;

    function automatic logic [31:0] compose_adr(input logic [31:0] base,
                                                input xfer_type_e t,
                                                input logic [3:0] word);
        return base + {25'd0, t, word, 1'b0};
    endfunction

    function automatic int word_count(input int gpio_count);
        return (gpio_count + 15) / 16;
    endfunction

endpackage

// File: rtl/wbm_single.sv
// Single classic-cycle Wishbone transfer engine with an ack timeout.
// Strobe only launches from an idle cycle, so every transfer is followed by a gap.
module wbm_single #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [15:0] req_dat,
    output logic        done,
    output logic        timeout,
    output logic [15:0] rdata,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [1:0]  bus_sel,
    output logic [31:0] bus_adr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(TIMEOUT);

    logic          stb_q;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q     <= 1'b0;
            tmo_cnt   <= '0;
            bus_we    <= 1'b0;
            bus_adr   <= '0;
            bus_wdata <= '0;
        end else if (stb_q) begin
            if (bus_ack || tmo_cnt == '0)
                stb_q <= 1'b0;
            else
                tmo_cnt <= tmo_cnt - CW'(1);
        end else if (req && !bus_ack) begin
            // never re-strobe while a late ack from the slave is still high
            stb_q     <= 1'b1;
            tmo_cnt   <= CW'(TIMEOUT - 1);
            bus_we    <= req_we;
            bus_adr   <= req_adr;
            bus_wdata <= req_dat;
        end
    end

    assign bus_cyc = stb_q;
    assign bus_stb = stb_q;
    assign bus_sel = stb_q ? 2'b11 : 2'b00;
    assign done    = stb_q & bus_ack;
    assign timeout = stb_q & ~bus_ack & (tmo_cnt == '0);
    assign rdata   = bus_rdata;

endmodule

// File: rtl/gpio_loop_walker.sv
// Wishbone master running a walking-one loopback test across the GPIO header
// (pin k wired to pin k+H); reports mismatching steps and ack timeouts.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for start_i
// ST_OE_WR   | enable lower-half drivers, one word per transfer
// ST_OUT_WR  | drive walking one for the current step
// ST_SETTLE  | let the loopback settle before sampling
// ST_IN_RD   | read all IN words into the capture buffer
// ST_CHECK   | compare capture against {p,p}, advance step
// ST_REL_OE  | release drivers (OE words of 0)
// ST_REL_OUT | clear OUT words
// ST_DONE    | publish done/pass, drop busy
module gpio_loop_walker
    import gpio_test_pkg::*;
#(
    parameter int          GPIO_COUNT = 48,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          SETTLE     = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [7:0]  first_err_step_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int              W         = word_count(GPIO_COUNT);
    localparam int              H         = GPIO_COUNT / 2;
    localparam int              NB        = W * 16;
    localparam int              SCW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [NB-1:0]   ONE       = NB'(1);
    localparam logic [NB-1:0]   OE_VEC    = (ONE << H) - ONE;
    localparam logic [NB-1:0]   PIN_MASK  = (ONE << GPIO_COUNT) - ONE;
    localparam logic [4:0]      LAST_WORD = 5'(W - 1);
    localparam logic [7:0]      LAST_STEP = 8'(H - 1);

    state_e         state;
    logic [7:0]     step;
    logic [4:0]     word;
    logic [SCW-1:0] settle_cnt;
    logic [NB-1:0]  capture;

    logic           req, req_we;
    logic [31:0]    req_adr;
    logic [15:0]    req_dat;
    xfer_type_e     xtype;
    int             wbase;
    logic [NB-1:0]  out_vec, expect_vec;
    logic           mismatch, last_word;
    logic           xfer_done, xfer_tmo;
    logic [15:0]    xfer_rdata;

    assign last_word  = (word == LAST_WORD);
    assign out_vec    = ONE << step;
    assign expect_vec = (ONE << step) | (ONE << (step + 8'(H)));
    assign mismatch   = |((capture ^ expect_vec) & PIN_MASK);

    always_comb begin
        req     = 1'b0;
        req_we  = 1'b1;
        xtype   = TYPE_OE;
        req_dat = '0;
        wbase   = int'(word) * 16;
        case (state)
            ST_OE_WR: begin
                req     = 1'b1;
                req_dat = OE_VEC[wbase +: 16];
            end
            ST_OUT_WR: begin
                req     = 1'b1;
                xtype   = TYPE_OUT;
                req_dat = out_vec[wbase +: 16];
            end
            ST_IN_RD: begin
                req    = 1'b1;
                req_we = 1'b0;
                xtype  = TYPE_IN;
            end
            ST_REL_OE: req = 1'b1;
            ST_REL_OUT: begin
                req   = 1'b1;
                xtype = TYPE_OUT;
            end
            default: req = 1'b0;
        endcase
        req_adr = compose_adr(BASE_ADR, xtype, word[3:0]);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state            <= ST_IDLE;
            step             <= '0;
            word             <= '0;
            settle_cnt       <= '0;
            capture          <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_step_o <= 8'hFF;
        end else if (xfer_tmo) begin
            // abort skips the release phase entirely
            timeout_o <= 1'b1;
            state     <= ST_DONE;
        end else begin
            if (xfer_done)
                word <= last_word ? 5'd0 : word + 5'd1;
            case (state)
                ST_IDLE: if (start_i) begin
                    busy_o           <= 1'b1;
                    done_o           <= 1'b0;
                    pass_o           <= 1'b0;
                    timeout_o        <= 1'b0;
                    err_count_o      <= '0;
                    first_err_step_o <= 8'hFF;
                    step             <= '0;
                    word             <= '0;
                    state            <= ST_OE_WR;
                end
                ST_OE_WR: if (xfer_done && last_word) state <= ST_OUT_WR;
                ST_OUT_WR: if (xfer_done && last_word) begin
                    settle_cnt <= SCW'(SETTLE - 1);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= ST_IN_RD;
                    else
                        settle_cnt <= settle_cnt - SCW'(1);
                end
                ST_IN_RD: if (xfer_done) begin
                    capture[wbase +: 16] <= xfer_rdata;
                    if (last_word) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
                        if (first_err_step_o == 8'hFF) first_err_step_o <= step;
                    end
                    if (step == LAST_STEP) begin
                        state <= ST_REL_OE;
                    end else begin
                        step  <= step + 8'd1;
                        state <= ST_OUT_WR;
                    end
                end
                ST_REL_OE: if (xfer_done && last_word) state <= ST_REL_OUT;
                ST_REL_OUT: if (xfer_done && last_word) state <= ST_DONE;
                ST_DONE: begin
                    done_o <= 1'b1;
                    pass_o <= (err_count_o == 16'd0) && !timeout_o;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wbm_single #(.TIMEOUT(TIMEOUT)) u_wbm (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .req       (req),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .done      (xfer_done),
        .timeout   (xfer_tmo),
        .rdata     (xfer_rdata),
        .bus_cyc   (wbm_cyc_o),
        .bus_stb   (wbm_stb_o),
        .bus_we    (wbm_we_o),
        .bus_sel   (wbm_sel_o),
        .bus_adr   (wbm_adr_o),
        .bus_wdata (wbm_dat_o),
        .bus_rdata (wbm_dat_i),
        .bus_ack   (wbm_ack_i)
    );

endmodule
